gen_operando_b: RTL and testbench

- Producer side of the ALU operand-B select path. From the decoded instruction fields it generates the three derived operands the operand-B selector consumes: the sign-extended immediate, the zero-extended immediate and the shifted register value.
- The shifted operand comes from an iterative (multi-cycle) shifter with a start/done handshake, so the control unit stalls operand selection until `done`.
- Sits between the decode stage/register file read port and the operand-B selector feeding the ALU.

---
 rtl/gen_operando_b_pkg.sv | 19 +
 rtl/gen_operando_b_ext_imm.sv | 17 +
 rtl/gen_operando_b.sv | 122 ++++++++++++
 tb/tb_gen_operando_b.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_operando_b_pkg.sv
// Shared types and constants for the operand-B generator: FSM states,
// shift-type encodings and default datapath widths.
package gen_operando_b_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_IMM_W = 16;
    localparam int SHAMT_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;

endpackage

// File: rtl/gen_operando_b_ext_imm.sv
// Combinational immediate extender producing the sign- and zero-extended
// forms of the raw instruction immediate.
module ext_imm
    import gen_operando_b_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IMM_W = DEF_IMM_W
) (
    input  logic [IMM_W-1:0] imm_i,
    output logic [WIDTH-1:0] simm_o,
    output logic [WIDTH-1:0] zimm_o
);

    assign simm_o = {{(WIDTH-IMM_W){imm_i[IMM_W-1]}}, imm_i};
    assign zimm_o = {{(WIDTH-IMM_W){1'b0}}, imm_i};

endmodule

// File: rtl/gen_operando_b.sv
// Operand-B producer: registers the extended immediates and runs an
// iterative shifter (up to STEP positions per cycle) behind a start/done handshake.
module gen_operando_b
    import gen_operando_b_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IMM_W = DEF_IMM_W,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [IMM_W-1:0]   imm,
    input  logic [WIDTH-1:0]   D0B,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         sh_type,
    output logic               busy,
    output logic               done,
    output logic               valid,
    output logic [WIDTH-1:0]   SImm,
    output logic [WIDTH-1:0]   ZImm,
    output logic [WIDTH-1:0]   Desplazado
);

    localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);

    state_e               state_q, state_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [1:0]           type_q, type_d;
    logic [WIDTH-1:0]     simm_q, simm_d;
    logic [WIDTH-1:0]     zimm_q, zimm_d;
    logic                 valid_q, valid_d;

    logic [WIDTH-1:0]     simm_w, zimm_w;
    logic [SHAMT_W-1:0]   step_n;
    logic [WIDTH-1:0]     shifted;
    logic                 accept;

    ext_imm #(
        .WIDTH (WIDTH),
        .IMM_W (IMM_W)
    ) u_ext_imm (
        .imm_i  (imm),
        .simm_o (simm_w),
        .zimm_o (zimm_w)
    );

    assign accept = (state_q == ST_IDLE) && start;
    assign step_n = (cnt_q < STEP_C) ? cnt_q : STEP_C;

    // SRA fills from the working MSB, which arithmetic shifts never change,
    // so it always equals the latched D0B sign bit.
    always_comb begin
        case (type_q)
            SH_SRL:  shifted = work_q >> step_n;
            SH_SRA:  shifted = WIDTH'($unsigned($signed(work_q) >>> step_n));
            default: shifted = work_q << step_n;
        endcase
    end

    // NOTE: every next-state signal takes its hold value first so no path
    // through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        type_d  = type_q;
        simm_d  = simm_q;
        zimm_d  = zimm_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    simm_d  = simm_w;
                    zimm_d  = zimm_w;
                    work_d  = D0B;
                    type_d  = sh_type;
                    cnt_d   = shamt;
                    state_d = (shamt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - step_n;
                if (cnt_q == step_n) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_DONE) || (valid_q && !accept);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            type_q  <= SH_SLL;
            simm_q  <= '0;
            zimm_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            type_q  <= type_d;
            simm_q  <= simm_d;
            zimm_q  <= zimm_d;
            valid_q <= valid_d;
        end
    end

    assign busy       = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign valid      = valid_q;
    assign SImm       = simm_q;
    assign ZImm       = zimm_q;
    assign Desplazado = work_q;

endmodule

// File: tb/tb_gen_operando_b.sv
// Directed bench for gen_operando_b: a STEP=1 and a STEP=4 instance share
// stimulus; expected values are hand-computed per scenario.
module tb_gen_operando_b;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] imm;
    logic [31:0] d0b;
    logic [4:0]  shamt;
    logic [1:0]  sh_type;

    logic        d1_busy, d1_done, d1_valid;
    logic [31:0] d1_simm, d1_zimm, d1_desp;
    logic        d4_busy, d4_done, d4_valid;
    logic [31:0] d4_simm, d4_zimm, d4_desp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gen_operando_b #(.WIDTH(32), .IMM_W(16), .STEP(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .imm(imm), .D0B(d0b),
        .shamt(shamt), .sh_type(sh_type), .busy(d1_busy), .done(d1_done),
        .valid(d1_valid), .SImm(d1_simm), .ZImm(d1_zimm), .Desplazado(d1_desp)
    );

    gen_operando_b #(.WIDTH(32), .IMM_W(16), .STEP(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .imm(imm), .D0B(d0b),
        .shamt(shamt), .sh_type(sh_type), .busy(d4_busy), .done(d4_done),
        .valid(d4_valid), .SImm(d4_simm), .ZImm(d4_zimm), .Desplazado(d4_desp)
    );

    // Pulses start for one cycle; returns at the negedge inside cycle k+1.
    task automatic issue(input logic [1:0] t, input logic [31:0] d,
                         input logic [4:0] sa, input logic [15:0] im);
        @(negedge clk);
        start = 1'b1; sh_type = t; d0b = d; shamt = sa; imm = im;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while ((d1_busy || d4_busy) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (d1_busy || d4_busy) begin
            n_err++;
            $display("FAIL wait_idle: busy1=%b busy4=%b still high after %0d cycles, required 0",
                     d1_busy, d4_busy, cyc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; imm = '0; d0b = '0; shamt = '0; sh_type = 2'b00;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({d1_busy, d1_done, d1_valid} !== 3'b000 || {d1_simm, d1_zimm, d1_desp} !== 96'd0) begin
            n_err++;
            $display("FAIL reset_dut1: busy/done/valid=%b%b%b simm=%h zimm=%h desp=%h, required all 0",
                     d1_busy, d1_done, d1_valid, d1_simm, d1_zimm, d1_desp);
        end
        n_cmp++;
        if ({d4_busy, d4_done, d4_valid} !== 3'b000 || {d4_simm, d4_zimm, d4_desp} !== 96'd0) begin
            n_err++;
            $display("FAIL reset_dut4: busy/done/valid=%b%b%b simm=%h zimm=%h desp=%h, required all 0",
                     d4_busy, d4_done, d4_valid, d4_simm, d4_zimm, d4_desp);
        end
        reset = 1'b0;
    endtask

    task automatic test_imm_ext();
        issue(2'b00, 32'h1, 5'd0, 16'h8001);
        n_cmp++;
        if (d1_simm !== 32'hFFFF8001) begin
            n_err++; $display("FAIL imm_simm: got %h, required FFFF8001", d1_simm);
        end
        n_cmp++;
        if (d1_zimm !== 32'h00008001) begin
            n_err++; $display("FAIL imm_zimm: got %h, required 00008001", d1_zimm);
        end
        n_cmp++;
        if (d1_desp !== 32'h1 || d1_done !== 1'b1 || d1_valid !== 1'b1 || d1_busy !== 1'b1) begin
            n_err++;
            $display("FAIL imm_k1: desp=%h done=%b valid=%b busy=%b, required 1/1/1/1",
                     d1_desp, d1_done, d1_valid, d1_busy);
        end
        n_cmp++;
        if (d4_done !== 1'b1 || d4_simm !== 32'hFFFF8001) begin
            n_err++; $display("FAIL imm_dut4: done=%b simm=%h, required 1 FFFF8001", d4_done, d4_simm);
        end
        @(negedge clk);
        n_cmp++;
        if (d1_done !== 1'b0 || d1_valid !== 1'b1 || d1_busy !== 1'b0) begin
            n_err++;
            $display("FAIL imm_k2: done=%b valid=%b busy=%b, required 0/1/0", d1_done, d1_valid, d1_busy);
        end
    endtask

    task automatic test_sll();
        issue(2'b00, 32'h0000_00F0, 5'd4, 16'h0);
        for (int c = 1; c <= 6; c++) begin
            n_cmp++;
            if (d1_busy !== (c <= 5) || d1_done !== (c == 5)) begin
                n_err++;
                $display("FAIL sll_cycle%0d: busy=%b done=%b, required %b %b",
                         c, d1_busy, d1_done, c <= 5, c == 5);
            end
            if (c == 5) begin
                n_cmp++;
                if (d1_desp !== 32'h0000_0F00) begin
                    n_err++; $display("FAIL sll_result: got %h, required 00000F00", d1_desp);
                end
            end
            if (c == 2) begin
                n_cmp++;
                if (d4_done !== 1'b1 || d4_desp !== 32'h0000_0F00) begin
                    n_err++; $display("FAIL sll_step4: done=%b desp=%h, required 1 00000F00", d4_done, d4_desp);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_shift_right();
        logic [1:0]  types [2] = '{2'b10, 2'b01};
        logic [31:0] exps  [2] = '{32'hFFFF_FFFF, 32'h0000_0001};
        for (int t = 0; t < 2; t++) begin
            issue(types[t], 32'h8000_0000, 5'd31, 16'h0);
            for (int c = 1; c <= 9; c++) begin
                n_cmp++;
                if (d4_done !== (c == 9)) begin
                    n_err++; $display("FAIL sr%0d_done_c%0d: got %b, required %b", t, c, d4_done, c == 9);
                end
                if (c < 9) @(negedge clk);
            end
            n_cmp++;
            if (d4_desp !== exps[t]) begin
                n_err++; $display("FAIL sr%0d_step4: got %h, required %h", t, d4_desp, exps[t]);
            end
            wait_idle();
            n_cmp++;
            if (d1_desp !== exps[t] || d1_valid !== 1'b1) begin
                n_err++; $display("FAIL sr%0d_step1: desp=%h valid=%b, required %h 1", t, d1_desp, d1_valid, exps[t]);
            end
        end
    endtask

    task automatic test_start_busy();
        issue(2'b01, 32'h0000_00F0, 5'd4, 16'h0);
        @(negedge clk);
        start = 1'b1; d0b = 32'h1234; sh_type = 2'b00; shamt = 5'd1;
        n_cmp++;
        if (d4_done !== 1'b1 || d4_desp !== 32'h0F) begin
            n_err++; $display("FAIL busy_step4_done: done=%b desp=%h, required 1 0000000F", d4_done, d4_desp);
        end
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (d4_busy !== 1'b0 || d4_desp !== 32'h0F) begin
            n_err++; $display("FAIL busy_step4_ignored: busy=%b desp=%h, required 0 0000000F", d4_busy, d4_desp);
        end
        @(negedge clk);
        n_cmp++;
        if (d1_done !== 1'b0) begin
            n_err++; $display("FAIL busy_step1_early: done=%b at k+4, required 0", d1_done);
        end
        @(negedge clk);
        n_cmp++;
        if (d1_done !== 1'b1 || d1_desp !== 32'h0F) begin
            n_err++; $display("FAIL busy_step1_result: done=%b desp=%h, required 1 0000000F", d1_done, d1_desp);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        issue(2'b00, 32'h1, 5'd10, 16'h7FFF);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({d1_busy, d1_done, d1_valid} !== 3'b000 || {d1_simm, d1_zimm, d1_desp} !== 96'd0) begin
            n_err++;
            $display("FAIL rstmid_dut1: busy/done/valid=%b%b%b simm=%h zimm=%h desp=%h, required all 0",
                     d1_busy, d1_done, d1_valid, d1_simm, d1_zimm, d1_desp);
        end
        n_cmp++;
        if ({d4_busy, d4_done, d4_valid} !== 3'b000 || {d4_simm, d4_zimm, d4_desp} !== 96'd0) begin
            n_err++;
            $display("FAIL rstmid_dut4: busy/done/valid=%b%b%b simm=%h zimm=%h desp=%h, required all 0",
                     d4_busy, d4_done, d4_valid, d4_simm, d4_zimm, d4_desp);
        end
        issue(2'b00, 32'h1, 5'd10, 16'h7FFF);
        for (int c = 1; c <= 11; c++) begin
            if (c == 4) begin
                n_cmp++;
                if (d4_done !== 1'b1 || d4_desp !== 32'h400) begin
                    n_err++; $display("FAIL rstmid_redo4: done=%b desp=%h, required 1 00000400", d4_done, d4_desp);
                end
            end
            if (c == 11) begin
                n_cmp++;
                if (d1_done !== 1'b1 || d1_desp !== 32'h400 || d1_simm !== 32'h0000_7FFF) begin
                    n_err++;
                    $display("FAIL rstmid_redo1: done=%b desp=%h simm=%h, required 1 00000400 00007FFF",
                             d1_done, d1_desp, d1_simm);
                end
            end
            @(negedge clk);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        issue(2'b01, 32'h10, 5'd2, 16'h0);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (d1_done !== 1'b1 || d1_desp !== 32'h4) begin
            n_err++; $display("FAIL b2b_first: done=%b desp=%h, required 1 00000004", d1_done, d1_desp);
        end
        issue(2'b10, 32'hF000_0000, 5'd4, 16'h0);
        n_cmp++;
        if (d1_valid !== 1'b0 || d1_busy !== 1'b1 || d4_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_accept: valid1=%b busy1=%b valid4=%b, required 0 1 0", d1_valid, d1_busy, d4_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (d4_done !== 1'b1 || d4_desp !== 32'hFF00_0000) begin
            n_err++; $display("FAIL b2b_step4: done=%b desp=%h, required 1 FF000000", d4_done, d4_desp);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (d1_done !== 1'b1 || d1_valid !== 1'b1 || d1_desp !== 32'hFF00_0000) begin
            n_err++;
            $display("FAIL b2b_step1: done=%b valid=%b desp=%h, required 1 1 FF000000", d1_done, d1_valid, d1_desp);
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_imm_ext();
        test_sll();
        test_shift_right();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
